tnn_infer_sequencer: RTL and testbench

- Sequences one approximate TNN classifier, the CGP-generated combinational cgp core with five 2-bit features and a 1-bit class output.
- Accepts features serially over a valid/ready stream and assembles them into the classifier's parallel input vector.
- Waits a programmable settle time, captures the class bit, and presents it on a valid/ready result port.
- Keeps saturating sample and positive-class statistics; sits between the dataset/feature DMA and the result collector.

---
 rtl/tnn_seq_pkg.sv | 19 +
 rtl/tnn_infer_sequencer_if.sv | 40 ++++
 rtl/tnn_sat_counter.sv | 34 +++
 rtl/tnn_infer_sequencer.sv | 157 +++++++++++++++
 tb/tb_tnn_infer_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tnn_seq_pkg.sv
// Shared types and defaults for the TNN inference sequencer.
package tnn_seq_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        EVAL    = 2'd1,
        OUT     = 2'd2
    } state_e;

    localparam int TNN_N_FEAT = 5;
    localparam int TNN_FEAT_W = 2;
    localparam int TNN_CNT_W  = 16;

    // Index width for a slot counter covering n entries (at least one bit).
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tnn_infer_sequencer_if.sv
// Feature stream, classifier, result and statistics signals of the sequencer.
interface tnn_infer_sequencer_if
    import tnn_seq_pkg::*;
#(
    parameter int N_FEAT = TNN_N_FEAT,
    parameter int FEAT_W = TNN_FEAT_W,
    parameter int CNT_W  = TNN_CNT_W
) ();

    // Both streams use valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; a raised valid holds its payload until then.
    logic                       in_valid;
    logic                       in_ready;
    logic [FEAT_W-1:0]          in_data;
    logic                       in_last;
    logic                       flush;
    logic                       clr_stats;
    logic [N_FEAT*FEAT_W-1:0]   feat_vec;
    logic                       cls_in;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_class;
    logic [CNT_W-1:0]           total_count;
    logic [CNT_W-1:0]           pos_count;
    logic                       err_framing;
    state_e                     dbg_state;

    modport master (
        output in_valid, in_data, in_last, flush, clr_stats, cls_in, out_ready,
        input  in_ready, feat_vec, out_valid, out_class, total_count, pos_count,
               err_framing, dbg_state
    );

    modport slave (
        input  in_valid, in_data, in_last, flush, clr_stats, cls_in, out_ready,
        output in_ready, feat_vec, out_valid, out_class, total_count, pos_count,
               err_framing, dbg_state
    );

endinterface

// File: rtl/tnn_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module tnn_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (inc_i && (q_q != {W{1'b1}})) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/tnn_infer_sequencer.sv
// Assembles serial features for the combinational TNN classifier, waits for it
// to settle, captures the class bit and hands it out with sample statistics.
module tnn_infer_sequencer
    import tnn_seq_pkg::*;
#(
    parameter int N_FEAT     = TNN_N_FEAT,
    parameter int FEAT_W     = TNN_FEAT_W,
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = TNN_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    tnn_infer_sequencer_if.slave  seq_if
);

    localparam int              IW          = idx_w(N_FEAT);
    localparam int              VW          = N_FEAT * FEAT_W;
    localparam logic [IW-1:0]   LAST_IDX    = IW'(N_FEAT - 1);
    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [VW-1:0]   feat_q, feat_d;
    logic [3:0]      settle_q, settle_d;
    logic            out_valid_q, out_valid_d;
    logic            out_class_q, out_class_d;
    logic            err_q, err_d;

    logic            in_ready;
    logic            beat_fire;
    logic            at_last;
    logic            frame_ok;
    logic            frame_err;
    logic            settle_done;
    logic            res_fire;
    logic            pos_fire;
    logic [CNT_W-1:0] total_q;
    logic [CNT_W-1:0] pos_q;

    // flush suppresses both handshakes in the cycle it is asserted.
    assign beat_fire   = seq_if.in_valid & in_ready & ~seq_if.flush;
    assign at_last     = (idx_q == LAST_IDX);
    assign frame_ok    = beat_fire & at_last & seq_if.in_last;
    assign frame_err   = beat_fire & (at_last != seq_if.in_last);
    assign settle_done = (state_q == EVAL) && (settle_q == SETTLE_LAST);
    assign res_fire    = out_valid_q & seq_if.out_ready & ~seq_if.flush;
    assign pos_fire    = res_fire & out_class_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (seq_if.flush) begin
            state_d = COLLECT;
        end else begin
            case (state_q)
                COLLECT: if (frame_ok)    state_d = EVAL;
                EVAL:    if (settle_done) state_d = OUT;
                OUT:     if (res_fire)    state_d = COLLECT;
                default:                  state_d = COLLECT;
            endcase
        end
    end

    always_comb begin
        in_ready = (state_q == COLLECT);
    end

    always_comb begin
        idx_d       = idx_q;
        feat_d      = feat_q;
        settle_d    = '0;
        out_valid_d = out_valid_q;
        out_class_d = out_class_q;
        err_d       = err_q;

        // A mis-framed beat is dropped entirely; the slot keeps its old value.
        if (frame_err) begin
            idx_d = '0;
            err_d = 1'b1;
        end else if (beat_fire) begin
            feat_d[idx_q*FEAT_W +: FEAT_W] = seq_if.in_data;
            idx_d = at_last ? '0 : idx_q + IW'(1);
        end

        if (state_q == EVAL) begin
            settle_d = settle_q + 4'd1;
        end
        if (settle_done) begin
            out_class_d = seq_if.cls_in;
            out_valid_d = 1'b1;
        end
        if (res_fire) begin
            out_valid_d = 1'b0;
            idx_d       = '0;
        end

        if (seq_if.flush) begin
            idx_d       = '0;
            out_valid_d = 1'b0;
            settle_d    = '0;
        end
        if (seq_if.clr_stats) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= '0;
            feat_q      <= '0;
            settle_q    <= '0;
            out_valid_q <= 1'b0;
            out_class_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            feat_q      <= feat_d;
            settle_q    <= settle_d;
            out_valid_q <= out_valid_d;
            out_class_q <= out_class_d;
            err_q       <= err_d;
        end
    end

    tnn_sat_counter #(.W(CNT_W)) u_total_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (seq_if.clr_stats),
        .inc_i (res_fire),
        .q_o   (total_q)
    );

    tnn_sat_counter #(.W(CNT_W)) u_pos_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (seq_if.clr_stats),
        .inc_i (pos_fire),
        .q_o   (pos_q)
    );

    assign seq_if.in_ready    = in_ready;
    assign seq_if.feat_vec    = feat_q;
    assign seq_if.out_valid   = out_valid_q;
    assign seq_if.out_class   = out_class_q;
    assign seq_if.total_count = total_q;
    assign seq_if.pos_count   = pos_q;
    assign seq_if.err_framing = err_q;
    assign seq_if.dbg_state   = state_q;

endmodule

// File: tb/tb_tnn_infer_sequencer.sv
// Randomised bench for the TNN inference sequencer against a sample-level model.
module tb_tnn_infer_sequencer;
    import tnn_seq_pkg::*;

    localparam int NF      = 5;
    localparam int FW      = 2;
    localparam int SC      = 4;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tnn_infer_sequencer_if #(.N_FEAT(NF), .FEAT_W(FW), .CNT_W(CW)) bus ();

    tnn_infer_sequencer #(
        .N_FEAT(NF), .FEAT_W(FW), .SETTLE_CYC(SC), .CNT_W(CW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .seq_if (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Sample-level reference: feature slots, framing position, stats, pending classes.
    logic [FW-1:0] m_feat [NF];
    int            m_idx;
    int            m_tot;
    int            m_pos;
    logic          m_err;
    logic [0:0]    exp_q [$];

    function automatic logic [NF*FW-1:0] model_vec();
        logic [NF*FW-1:0] v;
        v = '0;
        for (int k = 0; k < NF; k++) v[k*FW +: FW] = m_feat[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NF; k++) m_feat[k] = '0;
        m_idx = 0; m_tot = 0; m_pos = 0; m_err = 1'b0;
        exp_q.delete();
    endtask

    task automatic send_beat(input logic [FW-1:0] d, input logic last);
        int c;
        c = 0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = last;
        while (!bus.in_ready && c < 100) begin @(negedge clk); c++; end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL beat_accept: in_ready=%0b required 1", bus.in_ready);
        end
        @(posedge clk);
        if (last != (m_idx == NF - 1)) begin
            m_err = 1'b1; m_idx = 0;
        end else begin
            m_feat[m_idx] = d;
            if (m_idx == NF - 1) begin m_idx = 0; exp_q.push_back(bus.cls_in); end
            else m_idx++;
        end
        #1 bus.in_valid = 1'b0; bus.in_last = 1'b0;
    endtask

    task automatic send_frame(input logic cls);
        bus.cls_in = cls;
        for (int k = 0; k < NF; k++) send_beat(FW'($urandom_range(0, 3)), k == NF - 1);
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        @(negedge clk);
        while (!bus.out_valid && cyc < 64) begin @(negedge clk); cyc++; end
    endtask

    task automatic accept_result(input int hold);
        logic [0:0] e;
        e = exp_q.size() > 0 ? exp_q.pop_front() : 1'b0;
        repeat (hold) @(negedge clk);
        checks++;
        if (bus.out_class !== e[0] || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL result: out_valid=%0b out_class=%0b required 1/%0b",
                               bus.out_valid, bus.out_class, e[0]);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        m_tot = (m_tot < CNT_MAX) ? m_tot + 1 : CNT_MAX;
        if (e[0]) m_pos = (m_pos < CNT_MAX) ? m_pos + 1 : CNT_MAX;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (bus.feat_vec !== '0 || bus.out_valid !== 1'b0 || bus.out_class !== 1'b0 ||
            bus.total_count !== '0 || bus.pos_count !== '0 || bus.err_framing !== 1'b0) begin
            errors++; $display("FAIL reset_values: fv=%h ov=%0b oc=%0b tot=%0d pos=%0d err=%0b required all 0",
                               bus.feat_vec, bus.out_valid, bus.out_class, bus.total_count,
                               bus.pos_count, bus.err_framing);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: in_ready=%0b required 1", bus.in_ready);
        end
    endtask

    task automatic test_nominal();
        int c;
        bus.cls_in = 1'b1;
        send_beat(2'd1, 1'b0); send_beat(2'd2, 1'b0); send_beat(2'd3, 1'b0);
        send_beat(2'd0, 1'b0); send_beat(2'd1, 1'b1);
        wait_out(c);
        checks++;
        if (c != SC) begin errors++; $display("FAIL nominal_latency: cycles=%0d required %0d", c, SC); end
        checks++;
        if (bus.feat_vec !== 10'b01_00_11_10_01) begin
            errors++; $display("FAIL nominal_feat_vec: got %b required 0100111001", bus.feat_vec);
        end
        accept_result(0);
        @(negedge clk);
        checks++;
        if (bus.total_count !== CW'(m_tot) || bus.pos_count !== CW'(m_pos) || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL nominal_stats: tot=%0d pos=%0d rdy=%0b required %0d %0d 1",
                               bus.total_count, bus.pos_count, bus.in_ready, m_tot, m_pos);
        end
    endtask

    task automatic test_backpressure();
        int c;
        logic [0:0] e;
        send_frame(1'($urandom_range(0, 1)));
        wait_out(c);
        e = exp_q[0];
        for (int i = 0; i < 10; i++) begin
            bus.cls_in = ~bus.cls_in;
            @(negedge clk);
            checks++;
            if (bus.out_class !== e[0] || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                errors++; $display("FAIL backpressure_hold: oc=%0b rdy=%0b ov=%0b required %0b 0 1",
                                   bus.out_class, bus.in_ready, bus.out_valid, e[0]);
            end
        end
        accept_result(0);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.total_count !== CW'(m_tot)) begin
            errors++; $display("FAIL backpressure_release: rdy=%0b ov=%0b tot=%0d required 1 0 %0d",
                               bus.in_ready, bus.out_valid, bus.total_count, m_tot);
        end
    endtask

    task automatic check_no_result(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        repeat (cycles) begin @(negedge clk); if (bus.out_valid !== 1'b0) seen = 1'b1; end
        checks++;
        if (seen || bus.err_framing !== m_err || bus.in_ready !== 1'b1 || bus.feat_vec !== model_vec()) begin
            errors++; $display("FAIL %s: ov_seen=%0b err=%0b rdy=%0b fv=%h required 0 %0b 1 %h",
                               name, seen, bus.err_framing, bus.in_ready, bus.feat_vec, m_err, model_vec());
        end
    endtask

    task automatic clear_stats();
        @(negedge clk);
        bus.clr_stats = 1'b1;
        @(posedge clk);
        #1 bus.clr_stats = 1'b0;
        m_tot = 0; m_pos = 0; m_err = 1'b0;
    endtask

    task automatic test_framing();
        int c;
        bus.cls_in = 1'b0;
        send_beat(2'd3, 1'b0); send_beat(2'd2, 1'b0); send_beat(2'd1, 1'b1);
        check_no_result("framing_early_last", SC + 3);
        send_frame(1'($urandom_range(0, 1)));
        wait_out(c);
        accept_result(0);
        clear_stats();
        checks++;
        if (bus.err_framing !== 1'b0 || bus.total_count !== '0 || bus.pos_count !== '0) begin
            errors++; $display("FAIL clear_stats: err=%0b tot=%0d pos=%0d required 0 0 0",
                               bus.err_framing, bus.total_count, bus.pos_count);
        end
        for (int k = 0; k < NF; k++) send_beat(FW'($urandom_range(0, 3)), 1'b0);
        check_no_result("framing_missing_last", SC + 3);
        send_frame(1'b1);
        wait_out(c);
        checks++;
        if (c != SC || bus.feat_vec !== model_vec()) begin
            errors++; $display("FAIL framing_recover: cycles=%0d fv=%h required %0d %h",
                               c, bus.feat_vec, SC, model_vec());
        end
        accept_result(1);
    endtask

    task automatic test_flush();
        int c;
        send_frame(1'b1);
        repeat (2) @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        exp_q.delete();
        check_no_result("flush_eval", SC + 3);
        checks++;
        if (bus.total_count !== CW'(m_tot) || bus.pos_count !== CW'(m_pos)) begin
            errors++; $display("FAIL flush_eval_stats: tot=%0d pos=%0d required %0d %0d",
                               bus.total_count, bus.pos_count, m_tot, m_pos);
        end
        send_frame(1'b1);
        wait_out(c);
        bus.flush = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0; bus.out_ready = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.total_count !== CW'(m_tot) ||
            bus.pos_count !== CW'(m_pos)) begin
            errors++; $display("FAIL flush_out: ov=%0b rdy=%0b tot=%0d pos=%0d required 0 1 %0d %0d",
                               bus.out_valid, bus.in_ready, bus.total_count, bus.pos_count, m_tot, m_pos);
        end
    endtask

    task automatic test_saturation();
        int c;
        for (int i = 0; i < 20; i++) begin
            send_frame(1'b1);
            wait_out(c);
            accept_result(0);
        end
        @(negedge clk);
        checks++;
        if (bus.total_count !== CW'(m_tot) || bus.pos_count !== CW'(m_pos) || m_tot != CNT_MAX) begin
            errors++; $display("FAIL saturation: tot=%0d pos=%0d model=%0d/%0d required %0d",
                               bus.total_count, bus.pos_count, m_tot, m_pos, CNT_MAX);
        end
        send_frame(1'b1);
        wait_out(c);
        void'(exp_q.pop_front());
        bus.out_ready = 1'b1; bus.clr_stats = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0; bus.clr_stats = 1'b0;
        m_tot = 0; m_pos = 0; m_err = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.total_count !== '0 || bus.pos_count !== '0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL clear_vs_inc: tot=%0d pos=%0d ov=%0b required 0 0 0",
                               bus.total_count, bus.pos_count, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int c;
        send_frame(1'b1);
        wait_out(c);
        accept_result(0);
        send_beat(2'd1, 1'b0); send_beat(2'd2, 1'b1);
        for (int k = 0; k < 3; k++) send_beat(FW'($urandom_range(1, 3)), 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.feat_vec !== '0 || bus.out_valid !== 1'b0 || bus.total_count !== '0 ||
            bus.pos_count !== '0 || bus.err_framing !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid: fv=%h ov=%0b tot=%0d pos=%0d err=%0b rdy=%0b required 0 0 0 0 0 1",
                               bus.feat_vec, bus.out_valid, bus.total_count, bus.pos_count,
                               bus.err_framing, bus.in_ready);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.cls_in = 1'b0;
        send_beat(2'd3, 1'b0); send_beat(2'd3, 1'b0);
        check_no_result("reset_mid_partial", SC + 2);
        send_beat(2'd2, 1'b0); send_beat(2'd1, 1'b0); send_beat(2'd0, 1'b1);
        wait_out(c);
        checks++;
        if (c != SC || bus.feat_vec !== model_vec()) begin
            errors++; $display("FAIL reset_mid_frame: cycles=%0d fv=%h required %0d %h",
                               c, bus.feat_vec, SC, model_vec());
        end
        accept_result(0);
        @(negedge clk);
        checks++;
        if (bus.total_count !== CW'(m_tot) || bus.pos_count !== CW'(m_pos)) begin
            errors++; $display("FAIL reset_mid_stats: tot=%0d pos=%0d required %0d %0d",
                               bus.total_count, bus.pos_count, m_tot, m_pos);
        end
    endtask

    task automatic test_random();
        int c;
        int n;
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                n = $urandom_range(1, NF);
                for (int k = 0; k < n; k++)
                    send_beat(FW'($urandom_range(0, 3)), (k == n - 1) && (n != NF));
                check_no_result("random_bad_frame", 2);
            end
            send_frame(1'($urandom_range(0, 1)));
            wait_out(c);
            checks++;
            if (c != SC || bus.feat_vec !== model_vec()) begin
                errors++; $display("FAIL random_frame: cycles=%0d fv=%h required %0d %h",
                                   c, bus.feat_vec, SC, model_vec());
            end
            accept_result($urandom_range(0, 3));
            @(negedge clk);
            checks++;
            if (bus.total_count !== CW'(m_tot) || bus.pos_count !== CW'(m_pos) ||
                bus.err_framing !== m_err) begin
                errors++; $display("FAIL random_stats: tot=%0d pos=%0d err=%0b required %0d %0d %0b",
                                   bus.total_count, bus.pos_count, bus.err_framing, m_tot, m_pos, m_err);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
        bus.flush = 1'b0; bus.clr_stats = 1'b0; bus.cls_in = 1'b0; bus.out_ready = 1'b0;
        model_reset();
        test_reset();
        test_nominal();
        test_backpressure();
        test_framing();
        test_flush();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
